uart_tx_param: RTL and testbench
================================

// Module: uart_tx_param
// PURPOSE
//  Parametrised UART transmitter: next generation of the fixed 8N1 TX. Adds a
//  compile-time baud divider, configurable data width, parity and stop bits, a
//  valid/ready input handshake and a one-word holding buffer for gap-free
//  back-to-back frames. Sits between the host/command logic and the TX pad.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per serial bit (>=2)
//  DATA_BITS     8   payload bits per frame (5..9), sent LSB first
//  PARITY_MODE   0   0 = none, 1 = even, 2 = odd
//  STOP_BITS     1   stop bits per frame (1 or 2)
// PORTS
//  clk        in   1          system clock, all logic on rising edge
//  reset_n    in   1          asynchronous, active-low reset
//  tx_valid   in   1          host presents a word on tx_din
//  tx_din     in   DATA_BITS  word to transmit, sampled on accept
//  tx_ready   out  1          block can accept a word this cycle
//  tx_data    out  1          serial line (idle high), registered
//  tx_busy    out  1          frame in progress or word held
//  tx_done    out  1          1-cycle pulse at end of each frame's last stop bit
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low.
//  - Reset: tx_data=1, tx_ready=1, tx_busy=0, tx_done=0; FSM IDLE, hold empty,
//    counters 0. Reset mid-frame aborts at once; line returns high, no tx_done.
//  - Accept = tx_valid && tx_ready at a rising edge. tx_ready = !hold_full
//    (high while IDLE and while sending with an empty hold).
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
//    IDLE: tx_data=1. Accept loads shifter directly; START follows.
//    START: tx_data=0 for CLKS_PER_BIT cycles.
//    DATA: DATA_BITS bits, LSB first, each CLKS_PER_BIT cycles.
//    PARITY (PARITY_MODE!=0 only): even = XOR of payload; odd = its inverse.
//    STOP: tx_data=1 for STOP_BITS*CLKS_PER_BIT cycles.
//  - Latency: accept in IDLE at edge N -> tx_data low from edge N to N+CLKS_PER_BIT.
//  - Frame length = (1+DATA_BITS+(PARITY_MODE!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
//  - Baud counter counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT), wraps
//    at each bit boundary; bit index counter resets at each state change.
//  - Accept while not IDLE writes the hold register; tx_ready drops next cycle.
//  - End of last stop-bit cycle: tx_done pulses; if hold full, shifter loads
//    hold, START begins next cycle (zero idle gap), hold empties, tx_ready=1.
//    If hold empty and tx_valid is high on that edge, the word goes straight
//    to the shifter (no idle gap either). Otherwise go to IDLE.
//  - tx_busy = (state!=IDLE) || hold_full. tx_din changes after accept are
//    ignored. tx_valid while tx_ready=0 is ignored; the host must hold it.
// TESTING
//  1. Defaults, send 0xA5 -> line 0,1,0,1,0,0,1,0,1,1 (16 clk each); tx_done
//     at cycle 160 after accept; tx_ready stays 1 throughout.
//  2. PARITY_MODE=1, send 0x07 -> parity bit 1; PARITY_MODE=2 -> parity bit 0;
//     frame = 11*16 cycles.
//  3. Accept 0x55 then 0x0F while busy -> tx_ready low after 2nd accept; 2nd
//     start bit directly follows 1st stop bit, no idle cycle; 2 tx_done pulses.
//  4. Third tx_valid while hold full -> not accepted until hold drains; data
//     order preserved (0x55, 0x0F, third word).
//  5. reset_n low during DATA bit 3 -> tx_data=1, tx_busy=0, tx_ready=1 at once;
//     after release, new word 0x3C transmits correctly.
//  6. DATA_BITS=5, STOP_BITS=2, CLKS_PER_BIT=4, send 0x13 -> 1+5+2 bits =
//     32 cycles; bits 1,1,0,0,1 LSB first; line high for final 8 cycles.

Source files
------------

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready input, a one-word holding buffer
// for gap-free back-to-back frames, optional parity and one or two stop bits.
module uart_tx_param #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_din,
    output logic                 tx_ready,
    output logic                 tx_data,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W  = 4;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic              PAR_ODD   = 1'(PARITY_MODE == 2);
    localparam logic              HAS_PAR   = 1'(PARITY_MODE != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e               state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic                 ready_q, ready_d;
    logic                 data_q, data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic accept;
    logic bit_end;

    assign accept  = tx_valid && ready_q;
    assign bit_end = (baud_q == BAUD_LAST);

    // Next-state and next-output computation
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_d       = par_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        done_d      = 1'b0;

        if (accept && (state_q != S_IDLE)) begin
            hold_d      = tx_din;
            hold_full_d = 1'b1;
        end

        if (state_q != S_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (accept) begin
                    shift_d = tx_din;
                    par_d   = (^tx_din) ^ PAR_ODD;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        state_d = HAS_PAR ? S_PARITY : S_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        done_d = 1'b1;
                        bit_d  = '0;
                        // Chain straight into the next frame when a word is waiting
                        if (hold_full_q) begin
                            shift_d     = hold_q;
                            par_d       = (^hold_q) ^ PAR_ODD;
                            hold_full_d = 1'b0;
                            state_d     = S_START;
                        end else if (accept) begin
                            shift_d     = tx_din;
                            par_d       = (^tx_din) ^ PAR_ODD;
                            hold_full_d = 1'b0;
                            state_d     = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = !hold_full_d;
        busy_d  = (state_d != S_IDLE) || hold_full_d;

        case (state_d)
            S_START:  data_d = 1'b0;
            S_DATA:   data_d = shift_d[0];
            S_PARITY: data_d = par_d;
            default:  data_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b1;
            data_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ready_q     <= ready_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign tx_ready = ready_q;
    assign tx_data  = data_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: default 8N1, even/odd parity, back-to-back
// frames through the hold register, mid-frame reset, and a 5-bit/2-stop variant.
module tb_uart_tx_param;

    logic clk = 1'b0;
    logic reset_n;

    logic       valid_d;
    logic [7:0] din_d;
    logic       d_ready, d_data, d_busy, d_done;

    logic       valid_p;
    logic [7:0] din_p;
    logic       e_ready, e_data, e_busy, e_done;
    logic       o_ready, o_data, o_busy, o_done;

    logic       valid_s;
    logic [4:0] din_s;
    logic       s_ready, s_data, s_busy, s_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_param u_def (
        .clk(clk), .reset_n(reset_n), .tx_valid(valid_d), .tx_din(din_d),
        .tx_ready(d_ready), .tx_data(d_data), .tx_busy(d_busy), .tx_done(d_done)
    );

    uart_tx_param #(.PARITY_MODE(1)) u_even (
        .clk(clk), .reset_n(reset_n), .tx_valid(valid_p), .tx_din(din_p),
        .tx_ready(e_ready), .tx_data(e_data), .tx_busy(e_busy), .tx_done(e_done)
    );

    uart_tx_param #(.PARITY_MODE(2)) u_odd (
        .clk(clk), .reset_n(reset_n), .tx_valid(valid_p), .tx_din(din_p),
        .tx_ready(o_ready), .tx_data(o_data), .tx_busy(o_busy), .tx_done(o_done)
    );

    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(5), .STOP_BITS(2)) u_small (
        .clk(clk), .reset_n(reset_n), .tx_valid(valid_s), .tx_din(din_s),
        .tx_ready(s_ready), .tx_data(s_data), .tx_busy(s_busy), .tx_done(s_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Line level of bit slot k of an 8N1 frame carrying w
    function automatic logic fbit8(input logic [7:0] w, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return w[3'(k - 1)];
        return 1'b1;
    endfunction

    // Full default-DUT frame check, starting just after the accept edge
    task automatic run_frame_def(input logic [7:0] w, input string tag);
        for (int i = 1; i <= 161; i++) begin
            tick();
            if (i % 16 == 8) begin
                chk({tag, "_bit"}, d_data, fbit8(w, i / 16));
                chk({tag, "_ready"}, d_ready, 1'b1);
            end
            if (i == 159) chk({tag, "_done_early"}, d_done, 1'b0);
            if (i == 160) begin
                chk({tag, "_done"}, d_done, 1'b1);
                chk({tag, "_idle_line"}, d_data, 1'b1);
                chk({tag, "_idle_busy"}, d_busy, 1'b0);
            end
            if (i == 161) chk({tag, "_done_pulse"}, d_done, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] words [3];
        logic [4:0] w5;
        logic       exp_bit;
        int         fr;
        int         k;

        reset_n = 1'b0;
        valid_d = 1'b0; din_d = 8'h00;
        valid_p = 1'b0; din_p = 8'h00;
        valid_s = 1'b0; din_s = 5'h00;
        tick();
        tick();

        // Reset state of every instance
        chk("rst_d_data",  d_data,  1'b1); chk("rst_d_ready", d_ready, 1'b1);
        chk("rst_d_busy",  d_busy,  1'b0); chk("rst_d_done",  d_done,  1'b0);
        chk("rst_e_data",  e_data,  1'b1); chk("rst_e_ready", e_ready, 1'b1);
        chk("rst_e_busy",  e_busy,  1'b0); chk("rst_e_done",  e_done,  1'b0);
        chk("rst_o_data",  o_data,  1'b1); chk("rst_o_ready", o_ready, 1'b1);
        chk("rst_o_busy",  o_busy,  1'b0); chk("rst_o_done",  o_done,  1'b0);
        chk("rst_s_data",  s_data,  1'b1); chk("rst_s_ready", s_ready, 1'b1);
        chk("rst_s_busy",  s_busy,  1'b0); chk("rst_s_done",  s_done,  1'b0);

        reset_n = 1'b1;
        tick();

        // Test 1: 0xA5 on defaults
        valid_d = 1'b1; din_d = 8'hA5;
        tick();
        valid_d = 1'b0;
        chk("t1_start_latency", d_data, 1'b0);
        chk("t1_busy", d_busy, 1'b1);
        run_frame_def(8'hA5, "t1");

        // Test 2: 0x07 with even and odd parity, 11-bit frames
        valid_p = 1'b1; din_p = 8'h07;
        tick();
        valid_p = 1'b0;
        for (int i = 1; i <= 176; i++) begin
            tick();
            if (i % 16 == 8) begin
                k = i / 16;
                if (k == 9) begin
                    chk("t2_even_par", e_data, 1'b1);
                    chk("t2_odd_par",  o_data, 1'b0);
                end else begin
                    exp_bit = (k == 10) ? 1'b1 : fbit8(8'h07, k);
                    chk("t2_even_bit", e_data, exp_bit);
                    chk("t2_odd_bit",  o_data, exp_bit);
                end
            end
            if (i == 175) begin
                chk("t2_even_done_early", e_done, 1'b0);
                chk("t2_odd_done_early",  o_done, 1'b0);
            end
            if (i == 176) begin
                chk("t2_even_done", e_done, 1'b1);
                chk("t2_odd_done",  o_done, 1'b1);
            end
        end

        // Tests 3/4: 0x55, 0x0F into hold, 0x33 waits for the hold to drain
        words[0] = 8'h55; words[1] = 8'h0F; words[2] = 8'h33;
        valid_d = 1'b1; din_d = 8'h55;
        tick();
        chk("t3_first_start", d_data, 1'b0);
        chk("t3_ready_after_first", d_ready, 1'b1);
        din_d = 8'h0F;
        tick();
        chk("t3_ready_low", d_ready, 1'b0);
        chk("t3_busy", d_busy, 1'b1);
        din_d = 8'h33;
        for (int i = 2; i <= 480; i++) begin
            tick();
            if (i % 16 == 8) begin
                fr = i / 160;
                k  = (i % 160) / 16;
                chk("t3_bit", d_data, fbit8(words[2'(fr)], k));
            end
            if (i == 100) chk("t4_third_blocked", d_ready, 1'b0);
            if (i == 159 || i == 319 || i == 479) chk("t3_done_early", d_done, 1'b0);
            if (i == 160 || i == 320) begin
                chk("t3_done", d_done, 1'b1);
                chk("t3_no_gap", d_data, 1'b0);
                chk("t3_hold_drained", d_ready, 1'b1);
            end
            if (i == 161) begin
                chk("t4_third_accepted", d_ready, 1'b0);
                valid_d = 1'b0;
            end
            if (i == 321) chk("t3_done_pulse", d_done, 1'b0);
            if (i == 480) begin
                chk("t4_last_done", d_done, 1'b1);
                chk("t4_idle_line", d_data, 1'b1);
                chk("t4_idle_busy", d_busy, 1'b0);
                chk("t4_idle_ready", d_ready, 1'b1);
            end
        end
        tick();

        // Test 5: reset during data bit 3 of 0x00, then 0x3C
        valid_d = 1'b1; din_d = 8'h00;
        tick();
        valid_d = 1'b0;
        for (int i = 1; i <= 72; i++) tick();
        chk("t5_bit3_low", d_data, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_abort_line", d_data, 1'b1);
        chk("t5_abort_busy", d_busy, 1'b0);
        chk("t5_abort_ready", d_ready, 1'b1);
        chk("t5_abort_done", d_done, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("t5_no_done_after", d_done, 1'b0);
        valid_d = 1'b1; din_d = 8'h3C;
        tick();
        valid_d = 1'b0;
        chk("t5_start", d_data, 1'b0);
        run_frame_def(8'h3C, "t5");

        // Test 6: 5 data bits, 2 stop bits, 4 clocks per bit
        w5 = 5'h13;
        valid_s = 1'b1; din_s = w5;
        tick();
        valid_s = 1'b0;
        chk("t6_start", s_data, 1'b0);
        for (int i = 1; i <= 33; i++) begin
            tick();
            if (i < 24 && (i % 4 == 2)) begin
                k = i / 4;
                exp_bit = (k == 0) ? 1'b0 : w5[3'(k - 1)];
                chk("t6_bit", s_data, exp_bit);
            end
            if (i >= 24 && i <= 31) chk("t6_stop_high", s_data, 1'b1);
            if (i == 31) chk("t6_done_early", s_done, 1'b0);
            if (i == 32) begin
                chk("t6_done", s_done, 1'b1);
                chk("t6_idle_busy", s_busy, 1'b0);
            end
            if (i == 33) chk("t6_done_pulse", s_done, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
